// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// Data has priority; a bounded streak counter guarantees a pending fetch eventually wins.
module mem_port_arbiter #(
    parameter int AW         = 64,
    parameter int DW         = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          id_data_q, id_data_d;
    logic [31:0]   if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          pick_data;
    logic          first_cyc;
    logic          last_cyc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            streak_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            id_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            id_data_q <= id_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        streak_d  = streak_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        id_data_d = id_data_q;
        // Fetch overrides data only once data has won STARVE_MAX times in a row over it.
        pick_data = d_req && !(if_req && (streak_q == STARVE_LIM));
        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d   = ACCESS;
                    cnt_d     = '0;
                    id_data_d = pick_data;
                    if (pick_data) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                        if (if_req && (streak_q != STARVE_LIM)) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        we_d     = 1'b0;
                        streak_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign first_cyc = (state_q == ACCESS) && (cnt_q == '0);
    assign last_cyc  = (state_q == ACCESS) && (cnt_q == LAST_CNT);

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_done   = 1'b0;
        d_done    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        busy      = (state_q != IDLE);
        if (state_q == ACCESS) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_wr    = first_cyc && we_q;
            if_gnt    = first_cyc && !id_data_q;
            d_gnt     = first_cyc && id_data_q;
        end
        if (state_q == DONE) begin
            if_done = !id_data_q;
            d_done  = id_data_q;
        end
    end

    // Each port's read data holds until that port's next capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (last_cyc) begin
            if (id_data_q) begin
                d_rdata_q <= mem_rdata;
            end else begin
                if_rdata_q <= mem_rdata[31:0];
            end
        end
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all checked each
// cycle against a transaction-timestamp reference model and a behavioural memory.
module tb_mem_port_arbiter;

    localparam int AW         = 64;
    localparam int DW         = 64;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          if_gnt, if_done, d_gnt, d_done, mem_wr, busy;
    logic [31:0]   if_rdata;
    logic [DW-1:0] d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Behavioural memory: data appears MEM_LAT-1 cycles after the address (one register here).
    logic [DW-1:0] env_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    always @(posedge clk) begin
        mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);
        if (mem_wr) env_mem[mem_addr] = mem_wdata;
    end

    // Reference model state: timestamps of the current transaction.
    int            cyc = 0;
    int            next_arb = 0;
    int            gnt_cyc = -100;
    int            done_cyc = -100;
    int            streak = 0;
    bit            win_d = 1'b0;
    bit            w_we = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_wdata = '0;
    logic [DW-1:0] w_data = '0;
    logic [31:0]   exp_if_rdata = '0;
    logic [DW-1:0] exp_d_rdata = '0;
    bit            d_known = 1'b1;
    byte           dut_log[$];

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        env_mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_arbitrate();
        if (cyc >= next_arb && (if_req || d_req)) begin
            win_d = d_req && !(if_req && streak == STARVE_MAX);
            if (win_d) begin
                if (if_req && streak < STARVE_MAX) streak++;
                w_addr  = d_addr;
                w_we    = d_we;
                w_wdata = d_wdata;
                if (d_we) ref_mem[d_addr] = d_wdata;
                else      w_data = ref_read(d_addr);
            end else begin
                streak  = 0;
                w_addr  = if_addr;
                w_we    = 1'b0;
                w_wdata = '0;
                w_data  = ref_read(if_addr);
            end
            gnt_cyc  = cyc + 1;
            done_cyc = cyc + MEM_LAT + 1;
            next_arb = cyc + MEM_LAT + 2;
        end
    endtask

    task automatic check_outputs();
        bit in_acc, is_gnt, is_done;
        in_acc  = (cyc >= gnt_cyc) && (cyc < gnt_cyc + MEM_LAT);
        is_gnt  = (cyc == gnt_cyc);
        is_done = (cyc == done_cyc);
        if (is_done) begin
            if (!win_d)    exp_if_rdata = w_data[31:0];
            else if (w_we) d_known = 1'b0;
            else begin
                exp_d_rdata = w_data;
                d_known     = 1'b1;
            end
        end
        chk("if_gnt", if_gnt, is_gnt && !win_d);
        chk("d_gnt", d_gnt, is_gnt && win_d);
        chk("if_done", if_done, is_done && !win_d);
        chk("d_done", d_done, is_done && win_d);
        chk("busy", busy, (cyc >= gnt_cyc) && (cyc <= done_cyc));
        chk("mem_addr", mem_addr, in_acc ? w_addr : '0);
        chk("mem_wdata", mem_wdata, in_acc ? w_wdata : '0);
        chk("mem_wr", mem_wr, is_gnt && w_we);
        chk("if_rdata", if_rdata, exp_if_rdata);
        if (d_known) chk("d_rdata", d_rdata, exp_d_rdata);
        if (if_gnt) dut_log.push_back("I");
        if (d_gnt)  dut_log.push_back("D");
    endtask

    // Inputs for the current cycle are already set; entered and left at posedge+1.
    task automatic step();
        model_arbitrate();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_if_gnt"}, if_gnt, 1'b0);
        chk({tag, "_d_gnt"}, d_gnt, 1'b0);
        chk({tag, "_if_done"}, if_done, 1'b0);
        chk({tag, "_d_done"}, d_done, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
        chk({tag, "_mem_wr"}, mem_wr, 1'b0);
        chk({tag, "_if_rdata"}, if_rdata, '0);
        chk({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        #2;
        check_all_zero(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
        next_arb     = cyc;
        gnt_cyc      = -100;
        done_cyc     = -100;
        streak       = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        d_known      = 1'b1;
    endtask

    task automatic clear_reqs();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'({$urandom_range(0, 15), 3'b000});
    endfunction

    initial begin
        string starve_exp;
        clear_reqs();
        if_addr = '0;
        d_addr  = '0;
        d_wdata = '0;
        apply_reset("reset");

        // Single fetch
        preload(64'h10, 64'h0000_0000_00A0_0093);
        if_req = 1'b1; if_addr = 64'h10;
        steps(2);
        if_req = 1'b0;
        steps(3);
        chk("fetch_rdata", if_rdata, 32'h00A0_0093);

        // Store
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h40; d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        steps(2);
        clear_reqs();
        steps(3);
        chk("store_landed", env_mem.exists(64'h40) ? env_mem[64'h40] : '0, 64'hDEAD_BEEF_CAFE_F00D);

        // Contention: data first, fetch granted at t+5
        preload(64'h80, 64'h1234);
        dut_log.delete();
        if_req = 1'b1; if_addr = 64'h08;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h80;
        steps(2);
        d_req = 1'b0;
        steps(4);
        if_req = 1'b0;
        steps(4);
        chk("contention_d_rdata", d_rdata, 64'h1234);
        chk("contention_grants", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            chk("contention_first", dut_log[0], "D");
            chk("contention_second", dut_log[1], "I");
        end

        // Starvation bound
        apply_reset("reset2");
        dut_log.delete();
        if_req = 1'b1; if_addr = 64'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h88;
        steps(8 * (MEM_LAT + 2));
        clear_reqs();
        steps(4);
        starve_exp = "DDDIDDDI";
        chk("starve_count", dut_log.size(), 8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++) chk("starve_order", dut_log[i], starve_exp[i]);

        // Reset in the middle of a load, then a fresh fetch
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h50;
        steps(2);
        d_req = 1'b0;
        apply_reset("reset_mid");
        dut_log.delete();
        steps(6);
        chk("no_done_after_abort", dut_log.size(), 0);
        preload(64'h20, 64'h0000_0000_00B0_0113);
        if_req = 1'b1; if_addr = 64'h20;
        steps(2);
        if_req = 1'b0;
        steps(4);
        chk("fetch_after_reset", if_rdata, 32'h00B0_0113);

        // Missed request: data pulse only while busy
        dut_log.delete();
        if_req = 1'b1; if_addr = 64'h18;
        step();
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h48;
        steps(2);
        d_req = 1'b0;
        steps(10);
        chk("missed_grants", dut_log.size(), 1);
        if (dut_log.size() == 1) chk("missed_only_fetch", dut_log[0], "I");
        chk("missed_idle", busy, 1'b0);

        // Random traffic obeying the hold-until-grant rule
        clear_reqs();
        for (int n = 0; n < 800; n++) begin
            if (if_req && gnt_cyc == cyc - 1 && !win_d) if_req = 1'b0;
            if (d_req && gnt_cyc == cyc - 1 && win_d) d_req = 1'b0;
            if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req  = 1'b1;
                if_addr = rand_addr();
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = rand_addr();
                d_wdata = {$urandom, $urandom};
            end
            step();
        end
        clear_reqs();
        steps(2 * (MEM_LAT + 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares the single data-memory port (Memoria64-style, fixed read latency) between two requesters: the instruction-fetch path and the load/store path of the multicycle core. The block arbitrates, latches the winning request, drives the memory for MEM_LAT cycles, and returns the read data with a one-cycle done pulse. The control FSM stalls on the done pulse, so fetch and data access no longer need separate memories.

Parameters:
AW, 64, address width
DW, 64, data width (memory and data port)
MEM_LAT, 2, memory cycles from address presented to mem_rdata valid (>=1)
STARVE_MAX, 3, consecutive data grants allowed while a fetch is pending

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
if_req  in  1  fetch request, read-only
if_addr  in  AW  fetch address
if_gnt  out  1  fetch accepted (1-cycle pulse)
if_done  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  32  fetched instruction = mem_rdata[31:0]
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data (already formatted by the store block)
d_gnt  out  1  data accepted (1-cycle pulse)
d_done  out  1  data access complete (1-cycle pulse)
d_rdata  out  DW  load data
mem_addr  out  AW  memory read/write address
mem_wdata  out  DW  memory write data
mem_wr  out  1  memory write strobe
mem_rdata  in  DW  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0, including rdata registers. Streak counter is 0. An access in flight is aborted; no done is issued for it.
- FSM: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE, cycle t: if neither request is high, stay in IDLE. Otherwise:
  - Select a winner, latch its addr, wdata and we (we=0 for fetch) and its id.
  - Go to ACCESS and load cnt=0.
- Arbitration: data has fixed priority, except when if_req=1, d_req=1 and streak==STARVE_MAX; then fetch wins.
  - streak increments on a data grant while if_req=1.
  - streak clears on any fetch grant.
  - streak saturates at STARVE_MAX.
- ACCESS lasts exactly MEM_LAT cycles (t+1 .. t+MEM_LAT):
  - mem_addr and mem_wdata come from the latch; both are 0 outside ACCESS.
  - mem_wr=latched we in the first ACCESS cycle only.
  - The winner's gnt pulses high in the first ACCESS cycle (t+1).
  - In the last ACCESS cycle, mem_rdata is captured into if_rdata (low 32 bits) or d_rdata, chosen by id. A store also captures, and the value is don't-care.
- DONE, cycle t+MEM_LAT+1: the winner's done pulses high. Then IDLE at t+MEM_LAT+2, where the next arbitration occurs.
  - Throughput: one access per MEM_LAT+2 cycles.
- if_rdata and d_rdata hold their values until the next capture for the same port.
- Request rules:
  - A requester holds req, addr, wdata and we stable until it sees gnt, then may drop them.
  - req is sampled only in IDLE. A req raised and dropped while busy is never seen and never granted.
  - A req still high in IDLE after its own done is treated as a new request.
- Never both gnt high, never both done high, never gnt and done high in the same cycle.

Test Plan:
- Single fetch (MEM_LAT=2): if_req=1, if_addr=0x10 at t; memory returns 0x00A00093 → if_gnt at t+1; mem_addr=0x10 at t+1..t+2; mem_wr=0; if_done at t+3 with if_rdata=0x00A00093; busy t+1..t+3.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEFCAFEF00D at t → mem_wr=1 only at t+1 with mem_wdata=0xDEADBEEFCAFEF00D; d_gnt at t+1; d_done at t+3; no if_* pulses.
- Contention: if_req and d_req both high at t (d_addr=0x80, load 0x1234) → d_gnt at t+1 and d_done at t+3 with d_rdata=0x1234; if_gnt at t+5.
- Starvation (STARVE_MAX=3): if_req held high and d_req held high continuously → grant order D, D, D, I, D, D, D, I.
- Reset mid-access: rst=0 at t+2 of a load → all outputs 0 immediately; no d_done after release. A fresh fetch at 0x20 is then served with normal timing.
- Missed request: d_req pulsed high only during another access's ACCESS cycles → no d_gnt ever; FSM returns to IDLE and stays there.
